keypad_scanner: RTL
===================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 ROWS, 4, number of matrix rows; legal range 1..8.
REQ-002 COLS, 4, number of matrix columns; legal range 1..8.
REQ-003 SCAN_DIV, 1000, clk cycles each column is driven; legal range 1..65535.
REQ-004 DEBOUNCE, 4, consecutive identical scan frames required to accept a new state; legal range 1..15.
REQ-005 REPEAT_FRAMES, 0, frames between auto-repeat pulses while a key is held; 0 disables auto-repeat.
REQ-006 MAP_HEX, 1, 1 selects the team's hex keypad map; 0 selects linear map; 1 is legal only when ROWS=COLS=4.
REQ-007 KW, derived as clog2(ROWS*COLS) with a minimum of 4, is the key code width and is not user-set.
REQ-008 clk  input  1  single clock; all logic is clocked on its rising edge.
REQ-009 rst_n  input  1  asynchronous, active-low reset.
REQ-010 row_in  input  ROWS  row sense lines; 1 = key pressed on the driven column; already synchronised by the caller.
REQ-011 col_out  output  COLS  one-hot column drive.
REQ-012 key_code  output  KW  code of the last accepted key; held until the next accepted key.
REQ-013 key_valid  output  1  one-cycle pulse for each accepted key press or auto-repeat.
REQ-014 key_held  output  1  level; 1 while the debounced state is a single key.
REQ-015 multi_key  output  1  level; 1 while the debounced state is two or more keys.

Function
REQ-016 Column scan: col_out steps from bit COLS-1 down to bit 0, then wraps to COLS-1; each column is driven for exactly SCAN_DIV cycles.
REQ-017 Sampling: row_in is sampled in the last cycle of each column dwell; one frame is COLS consecutive dwells, starting at column COLS-1.
REQ-018 Frame result: NONE if no sample is set; SINGLE(code) if exactly one bit is set across the frame; MULTI otherwise.
REQ-019 Row index r = ROWS-1-bit position; column index c = COLS-1-bit position.
REQ-020 Linear map (MAP_HEX=0): code = r*COLS + c.
REQ-021 Hex map (MAP_HEX=1), rows listed from r=0, columns c=0..3: "1 2 3 A" / "4 5 6 B" / "7 8 9 C" / "F 0 E D" (F = *, E = #).
REQ-022 Stability counter: at frame end, if the result equals the previous frame's result, the counter increments, saturating at DEBOUNCE; otherwise it loads 1.
REQ-023 Debounced state FSM has states IDLE, HELD(code), and MULTI; the state changes only when the counter reaches DEBOUNCE and the stable result differs from the current state.
REQ-024 Entering HELD(X) from IDLE, MULTI, or HELD(Y) with Y != X: key_code <= X and key_valid pulses in the cycle after the frame-end sample.
REQ-025 Entering IDLE: key_held <= 0; no pulse; key_code is unchanged.
REQ-026 Entering MULTI: multi_key <= 1 and key_held <= 0; no pulse; key_code is unchanged.
REQ-027 Leaving MULTI clears multi_key in the same cycle as the new state update.
REQ-028 Auto-repeat: when REPEAT_FRAMES > 0 and the state is HELD, key_valid pulses again after every REPEAT_FRAMES further stable frames; the repeat counter clears on any state change.
REQ-029 Latency: for a clean press beginning before a frame starts, the first key_valid occurs DEBOUNCE*COLS*SCAN_DIV cycles after that frame starts, plus 1 cycle.
REQ-030 A bounce (a differing frame result) during debouncing restarts the count; no pulse is generated for a result that is not stable for DEBOUNCE frames.
REQ-031 key_valid is never high for two consecutive cycles.

Reset
REQ-032 While rst_n=0: col_out = 1 at bit COLS-1 only; key_code=0; key_valid=0; key_held=0; multi_key=0; state=IDLE; all counters=0; previous result=NONE.
REQ-033 Reset asserted mid-frame or mid-debounce discards the partial frame; scanning restarts at column COLS-1 on the first clk edge after rst_n rises.

Verification (SCAN_DIV=2, DEBOUNCE=3, ROWS=COLS=4, MAP_HEX=1 unless noted)
REQ-034 Check reset values, then the column drive sequence 1000,1000,0100,0100,0010,0010,0001,0001,1000 on successive cycles.
REQ-035 Hold row_in=1000 only while col_out=0001 (the A key) from frame start: expect key_code=0xA, one key_valid pulse at cycle 25, key_held=1.
REQ-036 Apply the "5" key pattern for 2 frames, release for 1 frame, then reapply: no pulse until 3 consecutive stable frames; then key_code=0x5.
REQ-037 Press "1" and "2" together: after 3 frames multi_key=1, no pulse, key_code is unchanged; releasing gives IDLE with multi_key=0.
REQ-038 REPEAT_FRAMES=2, hold "#" for 9 frames: key_code=0xE; pulses at the end of frames 3, 5, 7, and 9.
REQ-039 MAP_HEX=0, ROWS=2, COLS=3: press at r=1, c=2 -> key_code=5; assert rst_n=0 mid-debounce -> all outputs return to reset values.

Source files
------------

// File: rtl/keypad_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : keypad_scanner                                             |
// | Description : Matrix keypad column scanner with frame-based debounce,    |
// |               single/multi key classification, hex or linear key map     |
// |               and optional auto-repeat.                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module keypad_scanner #(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int SCAN_DIV      = 1000,
  parameter int DEBOUNCE      = 4,
  parameter int REPEAT_FRAMES = 0,
  parameter int MAP_HEX       = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ROWS-1:0]     row_in,
  output logic [COLS-1:0]     col_out,
  output logic [(($clog2(ROWS*COLS) > 4) ? $clog2(ROWS*COLS) : 4)-1:0] key_code,
  output logic                key_valid,
  output logic                key_held,
  output logic                multi_key
);

  localparam int KW  = ($clog2(ROWS*COLS) > 4) ? $clog2(ROWS*COLS) : 4;
  localparam int DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RBW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SW  = $clog2(DEBOUNCE + 1);
  localparam int RW  = (REPEAT_FRAMES > 0) ? $clog2(REPEAT_FRAMES + 1) : 1;

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } res_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HELD  = 2'd1,
    ST_MULTI = 2'd2
  } state_t;

  logic [DW-1:0]  div_q, div_d;
  logic [CW-1:0]  col_q, col_d;
  res_t           acc_kind_q, acc_kind_d;
  logic [KW-1:0]  acc_code_q, acc_code_d;
  res_t           prev_kind_q, prev_kind_d;
  logic [KW-1:0]  prev_code_q, prev_code_d;
  logic [SW-1:0]  stab_q, stab_d;
  logic [RW-1:0]  rep_q, rep_d;
  state_t         state_q, state_d;
  logic [KW-1:0]  key_code_q, key_code_d;
  logic           key_valid_q, key_valid_d;
  logic           key_held_q, key_held_d;
  logic           multi_key_q, multi_key_d;

  logic           dwell_end;
  logic           frame_end;
  logic [1:0]     row_hits;
  logic [RBW-1:0] row_bit;
  logic [KW-1:0]  sample_code;
  res_t           comb_kind;
  logic [KW-1:0]  comb_code;
  logic           fire;

  // The hex layout only exists for a 4x4 pad; any other geometry maps linearly.
  function automatic logic [KW-1:0] map_code(input int r, input int c);
    logic [3:0] hex;
    hex = 4'h0;
    if (MAP_HEX != 0 && ROWS == 4 && COLS == 4) begin
      case (r * 4 + c)
        0:       hex = 4'h1;
        1:       hex = 4'h2;
        2:       hex = 4'h3;
        3:       hex = 4'hA;
        4:       hex = 4'h4;
        5:       hex = 4'h5;
        6:       hex = 4'h6;
        7:       hex = 4'hB;
        8:       hex = 4'h7;
        9:       hex = 4'h8;
        10:      hex = 4'h9;
        11:      hex = 4'hC;
        12:      hex = 4'hF;
        13:      hex = 4'h0;
        14:      hex = 4'hE;
        default: hex = 4'hD;
      endcase
      map_code = KW'(hex);
    end else begin
      map_code = KW'(r * COLS + c);
    end
  endfunction

  // Column dwell timer and column stepping from COLS-1 down to 0.
  always_comb begin
    dwell_end = (div_q == DW'(SCAN_DIV - 1));
    frame_end = dwell_end && (col_q == '0);
    div_d     = dwell_end ? '0 : div_q + 1'b1;
    col_d     = col_q;
    if (dwell_end) begin
      col_d = (col_q == '0) ? CW'(COLS - 1) : col_q - 1'b1;
    end
    col_out = COLS'(1) << col_q;
  end

  // Count active rows (saturating at 2) and remember one active row position.
  always_comb begin
    row_hits = 2'd0;
    row_bit  = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (row_in[i]) begin
        if (row_hits != 2'd2) begin
          row_hits = row_hits + 2'd1;
        end
        row_bit = RBW'(i);
      end
    end
  end

  // Fold the current column sample into the running frame classification.
  always_comb begin
    sample_code = map_code(ROWS - 1 - int'(row_bit), COLS - 1 - int'(col_q));
    comb_kind   = acc_kind_q;
    comb_code   = acc_code_q;
    if (dwell_end && row_hits != 2'd0) begin
      if (acc_kind_q == RES_NONE && row_hits == 2'd1) begin
        comb_kind = RES_SINGLE;
        comb_code = sample_code;
      end else begin
        comb_kind = RES_MULTI;
        comb_code = '0;
      end
    end
    acc_kind_d = comb_kind;
    acc_code_d = comb_code;
    if (frame_end) begin
      acc_kind_d = RES_NONE;
      acc_code_d = '0;
    end
  end

  // Stability counting, debounced state transitions and key_valid generation.
  always_comb begin
    prev_kind_d = prev_kind_q;
    prev_code_d = prev_code_q;
    stab_d      = stab_q;
    rep_d       = rep_q;
    state_d     = state_q;
    key_code_d  = key_code_q;
    key_held_d  = key_held_q;
    multi_key_d = multi_key_q;
    fire        = 1'b0;
    if (frame_end) begin
      prev_kind_d = comb_kind;
      prev_code_d = comb_code;
      // Non-single results carry a zero code, so a plain compare is exact.
      if (comb_kind == prev_kind_q && comb_code == prev_code_q) begin
        stab_d = (stab_q == SW'(DEBOUNCE)) ? stab_q : stab_q + 1'b1;
      end else begin
        stab_d = SW'(1);
      end
      if (stab_d == SW'(DEBOUNCE)) begin
        case (comb_kind)
          RES_NONE: begin
            if (state_q != ST_IDLE) begin
              state_d     = ST_IDLE;
              key_held_d  = 1'b0;
              multi_key_d = 1'b0;
              rep_d       = '0;
            end
          end
          RES_SINGLE: begin
            if (state_q != ST_HELD || comb_code != key_code_q) begin
              state_d     = ST_HELD;
              key_code_d  = comb_code;
              key_held_d  = 1'b1;
              multi_key_d = 1'b0;
              rep_d       = '0;
              fire        = 1'b1;
            end else if (REPEAT_FRAMES > 0) begin
              if (rep_q == RW'(REPEAT_FRAMES - 1)) begin
                rep_d = '0;
                fire  = 1'b1;
              end else begin
                rep_d = rep_q + 1'b1;
              end
            end
          end
          default: begin
            if (state_q != ST_MULTI) begin
              state_d     = ST_MULTI;
              key_held_d  = 1'b0;
              multi_key_d = 1'b1;
              rep_d       = '0;
            end
          end
        endcase
      end
    end
    // With one-cycle frames a pulse could otherwise follow a pulse directly.
    key_valid_d = fire && !key_valid_q;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      col_q       <= CW'(COLS - 1);
      acc_kind_q  <= RES_NONE;
      acc_code_q  <= '0;
      prev_kind_q <= RES_NONE;
      prev_code_q <= '0;
      stab_q      <= '0;
      rep_q       <= '0;
      state_q     <= ST_IDLE;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_key_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      col_q       <= col_d;
      acc_kind_q  <= acc_kind_d;
      acc_code_q  <= acc_code_d;
      prev_kind_q <= prev_kind_d;
      prev_code_q <= prev_code_d;
      stab_q      <= stab_d;
      rep_q       <= rep_d;
      state_q     <= state_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      multi_key_q <= multi_key_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign multi_key = multi_key_q;

endmodule
`default_nettype wire
